vscpu_mem_sequencer: RTL and testbench
======================================

Name: vscpu_mem_sequencer

Overview:
- Run controller and RAM port owner for the 14-bit-address, 32-bit-word simple CPU.
- Host side loads and inspects RAM, launches a run, and stops it.
- While the CPU runs, the block muxes the single RAM port to the CPU and counts cycles.
- Outside a run it holds the CPU in reset and gives the RAM to the host.

Parameters:
ADDR_W, 14, RAM word-address width (matches CPU address bus)
DATA_W, 32, RAM/CPU data width
CNT_W, 24, width of run-cycle limit and cycle counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
host_cmd_valid  in  1  host command present
host_cmd_ready  out  1  command accepted when valid&&ready at posedge
host_cmd_op  in  2  00 WRITE, 01 READ, 10 RUN, 11 STOP
host_addr  in  ADDR_W  RAM address for WRITE/READ
host_wdata  in  DATA_W  write data for WRITE
run_cycles  in  CNT_W  RUN cycle limit, sampled on RUN accept; 0 = unlimited
host_rsp_valid  out  1  one-cycle pulse with READ data
host_rsp_data  out  DATA_W  READ result, valid only with host_rsp_valid
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a run ends
halt_by_limit  out  1  reason for last run end: 1 = limit reached, 0 = STOP; updated with done
cycle_count  out  CNT_W  RUN-state cycles of current/last run
cpu_rst  out  1  reset to CPU
cpu_wrEn  in  1  CPU write enable
cpu_addr  in  ADDR_W  CPU RAM address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  RAM read data to CPU
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid one cycle after address (synchronous read)

Behaviour:
- Reset: state IDLE; cpu_rst=1; host_rsp_valid=0, done=0, halt_by_limit=0, cycle_count=0, ram_we=0, ram_addr=0, ram_wdata=0; latched addr/data/limit cleared. Reset mid-run aborts the run with no done pulse.
- cpu_rdata = ram_rdata at all times. cpu_rst=1 in every state except RUN.
- States:
  - IDLE:
    - host_cmd_ready=1; RAM outputs 0, ram_we=0.
    - On accept, latch addr/wdata.
    - WRITE->HWR. READ->HRD.
    - RUN: latch limit; cycle_count<=0; ->CPURST.
    - STOP: accepted, no effect.
  - HWR: ram_we=1, ram_addr/ram_wdata = latched; ->IDLE. WRITE costs 2 cycles incl. accept.
  - HRD: ram_addr=latched, ram_we=0; ->HRSP.
  - HRSP: host_rsp_valid=1, host_rsp_data=ram_rdata; ->IDLE. Response arrives 2 cycles after accept.
  - CPURST: cpu_rst=1 for exactly one cycle so CPU registers clear; ->RUN.
  - RUN:
    - cpu_rst=0; ram_we/addr/wdata = cpu_wrEn/cpu_addr/cpu_wdata, combinational pass-through.
    - cycle_count increments each RUN cycle.
    - host_cmd_ready = host_cmd_valid && op==STOP; other ops are not accepted and wait.
    - End condition: STOP accepted, or limit!=0 and cycle_count+1==limit (run lasts exactly limit cycles).
    - On end: ->HALT; halt_by_limit <= limit condition (limit has priority when both are true the same cycle).
    - A CPU write issued in the final RUN cycle is committed.
  - HALT: cpu_rst=1, ram_we=0, done=1 for one cycle; ->IDLE.
- cycle_count holds after a run until the next RUN accept. In unlimited mode it wraps at 2^CNT_W with no halt.
- Only one command is in flight; host_cmd_ready=0 in HWR, HRD, HRSP, CPURST, HALT.

Test Plan:
- After reset: cpu_rst=1, busy=0, done=0, cycle_count=0, ram_we=0.
- WRITE addr 0x0005 data 0xDEADBEEF, then READ 0x0005 -> one ram_we pulse at addr 5; host_rsp_valid pulses 2 cycles after READ accept with 0xDEADBEEF.
- RUN run_cycles=5 with CPU stub driving cpu_addr=cycle index:
  - cpu_rst low for exactly 5 cycles after the 1-cycle CPURST;
  - ram_addr follows cpu_addr;
  - done pulses once, halt_by_limit=1, cycle_count=5.
- RUN run_cycles=0, STOP after 20 RUN cycles -> done pulses once, halt_by_limit=0, cycle_count=20. A READ issued during the run is held (ready=0) and is served after return to IDLE.
- RUN run_cycles=3 with STOP asserted in RUN cycle 3 -> single done pulse, halt_by_limit=1; CPU write (cpu_wrEn=1, addr 0x10, data 7) in cycle 3 appears on ram_we.
- rst asserted in RUN cycle 2 -> next cycle state IDLE, cpu_rst=1, no done pulse, cycle_count=0.

Source files
------------

// File: rtl/vscpu_mem_sequencer.sv
// Run controller and single-port RAM owner: host WRITE/READ/RUN/STOP, CPU muxed onto RAM only in RUN.
// WRITE commits 1 cycle after accept, READ data returns 2 cycles after accept; only STOP is accepted mid-run.
module vscpu_mem_sequencer #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_cmd_valid,
  output logic              host_cmd_ready,
  input  logic [1:0]        host_cmd_op,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [CNT_W-1:0]  run_cycles,
  output logic              host_rsp_valid,
  output logic [DATA_W-1:0] host_rsp_data,
  output logic              busy,
  output logic              done,
  output logic              halt_by_limit,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              cpu_rst,
  input  logic              cpu_wrEn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_HWR, S_HRD, S_HRSP, S_CPURST, S_RUN, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    limit_q, limit_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic                halt_by_limit_q, halt_by_limit_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                limit_hit;
  logic                stop_req;

  assign cnt_inc   = cycle_count_q + CNT_W'(1);
  assign limit_hit = (limit_q != '0) && (cnt_inc == limit_q);
  assign stop_req  = host_cmd_valid && (host_cmd_op == OP_STOP);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    limit_d         = limit_q;
    cycle_count_d   = cycle_count_q;
    halt_by_limit_d = halt_by_limit_q;
    host_cmd_ready  = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    case (state_q)
      S_IDLE: begin
        host_cmd_ready = 1'b1;
        if (host_cmd_valid) begin
          addr_d  = host_addr;
          wdata_d = host_wdata;
          case (host_cmd_op)
            OP_WRITE: state_d = S_HWR;
            OP_READ:  state_d = S_HRD;
            OP_RUN: begin
              limit_d       = run_cycles;
              cycle_count_d = '0;
              state_d       = S_CPURST;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_HWR: begin
        ram_we    = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        state_d   = S_IDLE;
      end
      S_HRD: begin
        ram_addr = addr_q;
        state_d  = S_HRSP;
      end
      S_HRSP:   state_d = S_IDLE;
      S_CPURST: state_d = S_RUN;
      S_RUN: begin
        // CPU owns the RAM port; its write in the final cycle still lands.
        host_cmd_ready = stop_req;
        ram_we         = cpu_wrEn;
        ram_addr       = cpu_addr;
        ram_wdata      = cpu_wdata;
        cycle_count_d  = cnt_inc;
        if (limit_hit || stop_req) begin
          state_d         = S_HALT;
          halt_by_limit_d = limit_hit;
        end
      end
      S_HALT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      limit_q         <= '0;
      cycle_count_q   <= '0;
      halt_by_limit_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      limit_q         <= limit_d;
      cycle_count_q   <= cycle_count_d;
      halt_by_limit_q <= halt_by_limit_d;
    end
  end

  assign host_rsp_valid = (state_q == S_HRSP);
  assign host_rsp_data  = (state_q == S_HRSP) ? ram_rdata : '0;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_HALT);
  assign halt_by_limit  = halt_by_limit_q;
  assign cycle_count    = cycle_count_q;
  assign cpu_rst        = (state_q != S_RUN);
  assign cpu_rdata      = ram_rdata;

endmodule

// File: tb/tb_vscpu_mem_sequencer.sv
// Self-checking bench for vscpu_mem_sequencer: host command table, RUN/STOP/limit corner sequences.
module tb_vscpu_mem_sequencer;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 24;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  logic              clk, rst;
  logic              host_cmd_valid, host_cmd_ready;
  logic [1:0]        host_cmd_op;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [CNT_W-1:0]  run_cycles;
  logic              host_rsp_valid;
  logic [DATA_W-1:0] host_rsp_data;
  logic              busy, done, halt_by_limit;
  logic [CNT_W-1:0]  cycle_count;
  logic              cpu_rst, cpu_wrEn;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  vscpu_mem_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_cmd_op(host_cmd_op), .host_addr(host_addr), .host_wdata(host_wdata),
    .run_cycles(run_cycles),
    .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data),
    .busy(busy), .done(done), .halt_by_limit(halt_by_limit), .cycle_count(cycle_count),
    .cpu_rst(cpu_rst), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM behind the sequencer.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int we_cnt   = 0;
  logic [DATA_W-1:0] exp_q [$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (host_rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got data 0x%0h expected no response", host_rsp_data);
      end else begin
        check("rsp_data", 64'(host_rsp_data), 64'(exp_q.pop_front()));
      end
    end
    if (done) done_cnt++;
    if (ram_we) we_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] lim);
    bit ok;
    ok = 1'b0;
    host_cmd_op = op; host_addr = a; host_wdata = d; run_cycles = lim;
    host_cmd_valid = 1'b1;
    #1;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (host_cmd_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    host_cmd_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: op %0d not accepted within 60 cycles", op);
    end
  endtask

  typedef struct {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rsp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int low, d0, w0;

    vecs[0] = '{OP_WRITE, 14'h0005, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{OP_READ,  14'h0005, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{OP_WRITE, 14'h3FFF, 32'hA5A5A5A5, 32'h0};
    vecs[3] = '{OP_WRITE, 14'h0000, 32'h12345678, 32'h0};
    vecs[4] = '{OP_READ,  14'h3FFF, 32'h0,        32'hA5A5A5A5};
    vecs[5] = '{OP_READ,  14'h0000, 32'h0,        32'h12345678};
    vecs[6] = '{OP_STOP,  14'h0000, 32'h0,        32'h0};
    vecs[7] = '{OP_READ,  14'h0005, 32'h0,        32'hDEADBEEF};

    rst = 1'b1; host_cmd_valid = 1'b0; host_cmd_op = OP_WRITE;
    host_addr = '0; host_wdata = '0; run_cycles = '0;
    cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cycle_count", 64'(cycle_count), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_halt_by_limit", 64'(halt_by_limit), 64'd0);
    check("rst_ready", 64'(host_cmd_ready), 64'd1);

    // Host command table
    for (int i = 0; i < 8; i++) begin
      w0 = we_cnt;
      if (vecs[i].op == OP_READ) exp_q.push_back(vecs[i].exp_rsp);
      send(vecs[i].op, vecs[i].addr, vecs[i].wdata, '0);
      case (vecs[i].op)
        OP_WRITE: begin
          check("hwr_we", 64'(ram_we), 64'd1);
          check("hwr_addr", 64'(ram_addr), 64'(vecs[i].addr));
          check("hwr_wdata", 64'(ram_wdata), 64'(vecs[i].wdata));
          step();
          check("hwr_we_pulses", 64'(we_cnt - w0), 64'd1);
          check("hwr_idle", 64'(busy), 64'd0);
        end
        OP_READ: begin
          check("hrd_rsp_early", 64'(host_rsp_valid), 64'd0);
          check("hrd_addr", 64'(ram_addr), 64'(vecs[i].addr));
          check("hrd_we", 64'(ram_we), 64'd0);
          step();
          check("hrsp_valid", 64'(host_rsp_valid), 64'd1);
          step();
          check("hrsp_pulse_end", 64'(host_rsp_valid), 64'd0);
        end
        default: begin
          check("idle_stop_busy", 64'(busy), 64'd0);
          check("idle_stop_done", 64'(done_cnt), 64'd0);
        end
      endcase
    end

    // RUN with limit 5; CPU stub drives cpu_addr = RUN cycle index
    d0 = done_cnt;
    send(OP_RUN, '0, '0, 24'd5);
    check("run5_cpurst", 64'(cpu_rst), 64'd1);
    check("run5_busy", 64'(busy), 64'd1);
    low = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      cpu_addr = ADDR_W'(low);
      #1;
      if (!cpu_rst) begin
        check("run5_ram_addr", 64'(ram_addr), 64'(low));
        low++;
      end
    end
    check("run5_low_cycles", 64'(low), 64'd5);
    check("run5_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("run5_halt_by_limit", 64'(halt_by_limit), 64'd1);
    check("run5_cycle_count", 64'(cycle_count), 64'd5);
    cpu_addr = '0;

    // Unlimited RUN, READ held during run, STOP in the 20th RUN cycle
    d0 = done_cnt;
    send(OP_RUN, '0, '0, 24'd0);
    for (int k = 0; k < 19; k++) begin
      step();
      if (k == 2) begin
        host_cmd_op = OP_READ; host_addr = 14'h0005; host_cmd_valid = 1'b1;
      end
      if (k == 10) begin
        #1;
        check("run_read_held", 64'(host_cmd_ready), 64'd0);
        check("run_cpu_rst", 64'(cpu_rst), 64'd0);
      end
    end
    step();
    host_cmd_op = OP_STOP;
    #1;
    check("stop_ready", 64'(host_cmd_ready), 64'd1);
    step();
    check("stop_done", 64'(done), 64'd1);
    check("stop_cpu_rst", 64'(cpu_rst), 64'd1);
    exp_q.push_back(32'hDEADBEEF);
    send(OP_READ, 14'h0005, '0, '0);
    check("stop_halt_by_limit", 64'(halt_by_limit), 64'd0);
    check("stop_cycle_count", 64'(cycle_count), 64'd20);
    step(); step();
    check("stop_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Limit 3 with STOP and a CPU write in the final RUN cycle
    d0 = done_cnt;
    send(OP_RUN, '0, '0, 24'd3);
    step(); step(); step();
    cpu_wrEn = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 32'd7;
    host_cmd_op = OP_STOP; host_cmd_valid = 1'b1;
    #1;
    check("lim3_cpu_we", 64'(ram_we), 64'd1);
    check("lim3_cpu_addr", 64'(ram_addr), 64'h10);
    check("lim3_cpu_wdata", 64'(ram_wdata), 64'd7);
    step();
    cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = '0; host_cmd_valid = 1'b0;
    #1;
    check("lim3_done", 64'(done), 64'd1);
    check("lim3_halt_by_limit", 64'(halt_by_limit), 64'd1);
    check("lim3_cycle_count", 64'(cycle_count), 64'd3);
    check("lim3_halt_we", 64'(ram_we), 64'd0);
    step();
    check("lim3_done_pulses", 64'(done_cnt - d0), 64'd1);
    exp_q.push_back(32'd7);
    send(OP_READ, 14'h0010, '0, '0);
    step(); step();

    // Reset in the middle of a run
    d0 = done_cnt;
    send(OP_RUN, '0, '0, 24'd0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("mrst_cycle_count", 64'(cycle_count), 64'd0);
    check("mrst_halt_by_limit", 64'(halt_by_limit), 64'd0);
    step(); step(); step();
    check("mrst_no_done", 64'(done_cnt - d0), 64'd0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    check("rsp_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
